uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first, fixed baud derived from the system clock.
//  Synchronises rx_in, detects the start bit and samples each bit at mid-period.
//  Presents each received byte with a one-cycle valid pulse.
//  Collects bytes into an internal line buffer and flags end-of-string; feeds
//  the command parser of the PWM generator.
// PARAMETERS
//  ClkFreq       50_000_000  system clock frequency, Hz
//  BaudRate      115200      line rate, bit/s
//  RXBuferDepth  32          line buffer depth, bytes
//  EosChar       8'h0A       end-of-string byte
// PORTS
//  clk_50mhz    in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous, active-high reset (asserted when 1)
//  rx_in        in   1  serial line, idle high, asynchronous to clk
//  rx_data      out  8  last received byte, stable until next valid byte
//  rx_valid     out  1  one-cycle pulse: rx_data holds a new byte
//  eos_flag     out  1  one-cycle pulse, coincident with rx_valid when rx_data==EosChar
//  buffer_full  out  1  level: line buffer holds RXBuferDepth bytes
// BEHAVIOUR
//  - Constants: BAUD_TICKS = ClkFreq/BaudRate (434 at defaults, integer division);
//    HALF_TICKS = BAUD_TICKS/2 (217).
//  - Reset: all outputs 0; FSM=IDLE; counters 0; buffer count 0;
//    synchroniser flops reset to 1 (idle).
//  - rx_in passes through a 2-flop synchroniser; FSM uses the synchronised rx_s only.
//  - baud_tick: internal one-cycle pulse when the baud counter reaches its terminal
//    count. The counter reloads on every state entry.
//  - FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
//     IDLE: rx_s==0 -> START_BIT; counter cleared.
//     START_BIT: after HALF_TICKS cycles sample rx_s. If 0 -> DATA_BITS; if 1 (glitch)
//       -> IDLE, no output.
//     DATA_BITS: every BAUD_TICKS cycles sample rx_s into shift[bit_idx], bit 0 first.
//       After bit 7 -> STOP_BIT.
//     STOP_BIT: after BAUD_TICKS cycles sample rx_s.
//       If 1: rx_data<=shift and rx_valid=1 for exactly one cycle; byte written to
//       buffer; -> IDLE.
//       If 0 (framing error): byte discarded, no rx_valid; -> IDLE.
//  - Latency: rx_valid rises about 9.5 bit periods after the start-bit falling edge,
//    plus 2 synchroniser cycles.
//  - Buffer: write on each valid byte while count<RXBuferDepth. When full, further
//    bytes still pulse rx_valid but are not stored. buffer_full=(count==RXBuferDepth).
//    After writing an EosChar byte, count clears to 0 on the next cycle.
//  - Reset asserted mid-frame: immediate return to IDLE, partial byte lost,
//    no pulse on deassert.
// CONFIGURATION
//  UART_RX_FRAME_ERR_EN defined: adds output port frame_err (1 bit, reset 0). It pulses
//   one cycle when the stop-bit sample is 0.
//  Undefined: no frame_err port; bad frames are dropped silently.
// STRUCTURE
//  uart_pkg: rx_state_e enum (IDLE, START_BIT, DATA_BITS, STOP_BIT), BAUD_TICKS and
//   HALF_TICKS computation function, default EOS constant.
//  One sub-module, uart_rx_buffer: byte store, count, full flag, clear-on-EOS.
//  FSM and baud counter stay in uart_rx.
// TESTING
//  1 Send 0xAA (start, bits LSB first, stop) at 8680 ns/bit -> one rx_valid pulse,
//    rx_data==8'hAA, eos_flag=0.
//  2 Pulse rx_in low for 100 ns (5 clks) -> FSM IDLE->START_BIT->IDLE, no rx_valid
//    for 2 bit periods.
//  3 Send 0x0A -> rx_valid and eos_flag high in the same cycle; buffer count 0 next cycle.
//  4 Send 32 bytes of 0x55 -> buffer_full=1 after the 32nd; 33rd byte still pulses
//    rx_valid, buffer_full stays 1.
//  5 Send 0x3C with stop bit held 0 -> no rx_valid; frame_err pulse when
//    UART_RX_FRAME_ERR_EN is defined.
//  6 Assert rst_n during bit 4 of a frame -> all outputs 0 at once; next clean 0x81
//    frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   rx_state_e       receiver FSM state encoding
//   EOS_DEFAULT      default end-of-string byte (line feed)
//   calc_baud_ticks  system clocks per bit period (integer division)
//   calc_half_ticks  system clocks per half bit period
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } rx_state_e;

  localparam logic [7:0] EOS_DEFAULT = 8'h0A;

  function automatic int calc_baud_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_ticks(input int clk_freq, input int baud_rate);
    return calc_baud_ticks(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: line buffer behind the UART receiver.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   wr_en    in   one-cycle strobe: wr_data is a good received byte
//   wr_data  in   received byte
//   rd_addr  in   read address for the downstream command parser
//   rd_data  out  registered read data (one cycle after rd_addr)
//   full     out  level: buffer holds Depth bytes
// Bytes are stored while space remains; a terminator byte clears the count on
// the following cycle so the next line starts at address 0.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int         Depth   = 32,
  parameter logic [7:0] EosChar = EOS_DEFAULT,
  localparam int        AW      = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int        CW      = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          full
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(Depth);

  logic [7:0]    mem [Depth];
  logic [CW-1:0] count_reg;
  logic          eos_pending_reg;
  logic          wr_ok;

  assign wr_ok = wr_en && (count_reg != DEPTH_CNT);
  assign full  = (count_reg == DEPTH_CNT);

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count_reg[AW-1:0]] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // The terminator restarts the line even when it arrives on a full buffer,
  // otherwise an over-long line would leave the buffer wedged at full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg       <= '0;
      eos_pending_reg <= 1'b0;
    end else begin
      eos_pending_reg <= wr_en && (wr_data == EosChar);
      if (eos_pending_reg) begin
        count_reg <= '0;
      end else if (wr_ok) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, fixed baud from the system clock.
// Ports:
//   clk_50mhz    in   system clock
//   rst_n        in   asynchronous reset, active HIGH despite the name
//   rx_in        in   serial line, idle high, asynchronous
//   rx_data      out  last good byte, held until the next one
//   rx_valid     out  one-cycle pulse per good byte
//   eos_flag     out  one-cycle pulse with rx_valid when the byte is EosChar
//   buffer_full  out  level: line buffer holds RXBuferDepth bytes
//   frame_err    out  (only with UART_RX_FRAME_ERR_EN) one-cycle pulse when
//                     the stop bit samples low
// Configuration macro: UART_RX_FRAME_ERR_EN. Without it bad frames are dropped
// silently and the frame_err port does not exist.
module uart_rx
  import uart_pkg::*;
#(
  parameter int         ClkFreq      = 50_000_000,
  parameter int         BaudRate     = 115200,
  parameter int         RXBuferDepth = 32,
  parameter logic [7:0] EosChar      = EOS_DEFAULT
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       eos_flag,
  output logic       buffer_full
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int BAUD_TICKS = calc_baud_ticks(ClkFreq, BaudRate);
  localparam int HALF_TICKS = calc_half_ticks(ClkFreq, BaudRate);
  localparam int CNT_W      = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int BUF_AW     = (RXBuferDepth > 1) ? $clog2(RXBuferDepth) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

  rx_state_e        state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             sync1_reg;
  logic             rx_s;
  logic             baud_tick;
  logic             sample_data;
  logic             stop_ok;
  logic [7:0]       bit_sel;
  logic [7:0]       buf_rd_data_unused;

  // Two-flop synchroniser; reset to the idle line level.
  always_ff @(posedge clk_50mhz or posedge rst_n) begin
    if (rst_n) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx_in;
      rx_s      <= sync1_reg;
    end
  end

  // Start bit waits half a period so every later sample lands mid-bit.
  assign baud_tick   = (state_reg != IDLE) &&
                       (baud_cnt_reg == ((state_reg == START_BIT) ? HALF_LAST : BAUD_LAST));
  assign sample_data = (state_reg == DATA_BITS) && baud_tick;
  assign stop_ok     = (state_reg == STOP_BIT) && baud_tick && rx_s;

  // One-hot select of the data bit being captured this period.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit_sel
      assign bit_sel[gi] = sample_data && (bit_idx_reg == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk_50mhz or posedge rst_n) begin
    if (rst_n) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= (shift_reg & ~bit_sel) | ({8{rx_s}} & bit_sel);
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      eos_flag     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      eos_flag <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      // Every state change happens on a tick or out of IDLE, so this also
      // reloads the counter on each state entry.
      if (baud_tick || state_reg == IDLE) begin
        baud_cnt_reg <= '0;
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START_BIT;
          end
        end
        START_BIT: begin
          if (baud_tick) begin
            bit_idx_reg <= '0;
            state_reg   <= rx_s ? IDLE : DATA_BITS;
          end
        end
        DATA_BITS: begin
          if (baud_tick) begin
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP_BIT;
            end
          end
        end
        STOP_BIT: begin
          if (baud_tick) begin
            state_reg <= IDLE;
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              eos_flag <= (shift_reg == EosChar);
            end
`ifdef UART_RX_FRAME_ERR_EN
            else begin
              frame_err <= 1'b1;
            end
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Written on the same edge that raises rx_valid. The read port is reserved
  // for the command parser, which is not yet routed out of this block.
  uart_rx_buffer #(
    .Depth   (RXBuferDepth),
    .EosChar (EosChar)
  ) u_buf (
    .clk     (clk_50mhz),
    .rst     (rst_n),
    .wr_en   (stop_ok),
    .wr_data (shift_reg),
    .rd_addr ({BUF_AW{1'b0}}),
    .rd_data (buf_rd_data_unused),
    .full    (buffer_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. The line rate is raised to 1 Mbit/s
// (50 clocks per bit) so the 33-byte buffer scenario stays short; all bit
// timing below is derived from the same constants.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_NS = 20;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int BIT_NS = CLK_NS * (CLK_HZ / BAUD);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       eos_flag;
  logic       buffer_full;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int errors = 0;
  int checks = 0;

  // Monitor state, sampled on the falling edge.
  int         valid_cnt = 0;
  int         dbl_valid = 0;
  int         stray_eos = 0;
  int         ferr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_eos = 1'b0;
  longint     last_valid_t = 0;
  int         cnt_at_valid = -1;
  int         cnt_after_valid = -1;
  logic       prev_valid = 1'b0;
  logic       saw_start = 1'b0;

  uart_rx #(
    .ClkFreq      (CLK_HZ),
    .BaudRate     (BAUD),
    .RXBuferDepth (32),
    .EosChar      (8'h0A)
  ) dut (
    .clk_50mhz   (clk),
    .rst_n       (rst),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .eos_flag    (eos_flag),
    .buffer_full (buffer_full)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(negedge clk) begin
    if (prev_valid) cnt_after_valid = int'(dut.u_buf.count_reg);
    if (rx_valid) begin
      valid_cnt++;
      last_data    = rx_data;
      last_eos     = eos_flag;
      last_valid_t = $time;
      cnt_at_valid = int'(dut.u_buf.count_reg);
      if (prev_valid) dbl_valid++;
    end
    if (eos_flag && !rx_valid) stray_eos++;
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) ferr_cnt++;
`endif
    if (dut.state_reg == START_BIT) saw_start = 1'b1;
    prev_valid = rx_valid;
  end

  // Drives one frame starting at a falling clock edge; returns with the line
  // high at the end of the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, output longint t_fall);
    @(negedge clk);
    t_fall = $time;
    rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      #(BIT_NS);
    end
    rx_in = stop;
    #(BIT_NS);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (eos_flag !== 1'b0) begin errors++; $display("FAIL reset_eos got=%b exp=0", eos_flag); end
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", buffer_full); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_reg, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_byte;
    int v0;
    longint tf;
    longint lat;
    v0 = valid_cnt;
    send_frame(8'hAA, 1'b1, tf);
    #(BIT_NS);
    lat = last_valid_t - tf;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL aa_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if (last_data !== 8'hAA) begin errors++; $display("FAIL aa_data got=%h exp=aa", last_data); end
    checks++; if (last_eos !== 1'b0) begin errors++; $display("FAIL aa_eos got=%b exp=0", last_eos); end
    checks++; if (cnt_at_valid !== 1) begin errors++; $display("FAIL aa_buf_count got=%0d exp=1", cnt_at_valid); end
    // Mid-stop sample is 9.5 bits after the edge, plus synchroniser cycles.
    checks++; if (lat < 9 * BIT_NS + BIT_NS / 2 || lat > 9 * BIT_NS + BIT_NS / 2 + 10 * CLK_NS) begin
      errors++; $display("FAIL aa_latency got=%0d ns exp=%0d..%0d ns", lat, 9 * BIT_NS + BIT_NS / 2, 9 * BIT_NS + BIT_NS / 2 + 10 * CLK_NS);
    end
    $display("test_single_byte sent=aa got=%h", last_data);
  endtask

  task automatic test_glitch;
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    saw_start = 1'b0;
    rx_in = 1'b0;
    #(5 * CLK_NS);
    rx_in = 1'b1;
    #(2 * BIT_NS);
    checks++; if (saw_start !== 1'b1) begin errors++; $display("FAIL glitch_start got=%b exp=1", saw_start); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", valid_cnt - v0); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_reg, IDLE); end
    $display("test_glitch pulses=%0d", valid_cnt - v0);
  endtask

  task automatic test_eos;
    int v0;
    longint tf;
    v0 = valid_cnt;
    send_frame(8'h0A, 1'b1, tf);
    #(BIT_NS);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL eos_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if (last_eos !== 1'b1) begin errors++; $display("FAIL eos_flag got=%b exp=1", last_eos); end
    checks++; if (last_data !== 8'h0A) begin errors++; $display("FAIL eos_data got=%h exp=0a", last_data); end
    checks++; if (cnt_at_valid !== 2) begin errors++; $display("FAIL eos_count_write got=%0d exp=2", cnt_at_valid); end
    checks++; if (cnt_after_valid !== 0) begin errors++; $display("FAIL eos_count_clear got=%0d exp=0", cnt_after_valid); end
    $display("test_eos sent=0a got=%h eos=%b", last_data, last_eos);
  endtask

  task automatic test_back_to_back;
    int v0;
    longint tf;
    v0 = valid_cnt;
    for (int i = 0; i < 31; i++) send_frame(8'h55, 1'b1, tf);
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL fill31_full got=%b exp=0", buffer_full); end
    send_frame(8'h55, 1'b1, tf);
    checks++; if (buffer_full !== 1'b1) begin errors++; $display("FAIL fill32_full got=%b exp=1", buffer_full); end
    send_frame(8'h55, 1'b1, tf);
    #(BIT_NS);
    checks++; if (valid_cnt - v0 !== 33) begin errors++; $display("FAIL fill_pulses got=%0d exp=33", valid_cnt - v0); end
    checks++; if (buffer_full !== 1'b1) begin errors++; $display("FAIL fill33_full got=%b exp=1", buffer_full); end
    checks++; if (dut.u_buf.count_reg !== 6'd32) begin errors++; $display("FAIL fill_count got=%0d exp=32", dut.u_buf.count_reg); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL fill_data got=%h exp=55", last_data); end
    checks++; if (dbl_valid !== 0) begin errors++; $display("FAIL valid_width got=%0d long pulses exp=0", dbl_valid); end
    checks++; if (stray_eos !== 0) begin errors++; $display("FAIL stray_eos got=%0d exp=0", stray_eos); end
    $display("test_back_to_back pulses=%0d full=%b", valid_cnt - v0, buffer_full);
  endtask

  task automatic test_frame_error;
    int v0;
    int f0;
    longint tf;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, tf);
    #(2 * BIT_NS);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_pulses got=%0d exp=0", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ferr_data_held got=%h exp=55", rx_data); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL ferr_state got=%0d exp=%0d", dut.state_reg, IDLE); end
`ifdef UART_RX_FRAME_ERR_EN
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", ferr_cnt - f0); end
`endif
    $display("test_frame_error pulses=%0d frame_err_pulses=%0d", valid_cnt - v0, ferr_cnt - f0);
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    longint tf;
    logic [7:0] partial;
    partial = 8'hF0;
    @(negedge clk);
    rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      #(BIT_NS);
    end
    rx_in = partial[4];
    #(BIT_NS / 2);
    checks++; if (dut.state_reg !== DATA_BITS) begin errors++; $display("FAIL mid_state_before got=%0d exp=%0d", dut.state_reg, DATA_BITS); end
    rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (eos_flag !== 1'b0) begin errors++; $display("FAIL mid_eos got=%b exp=0", eos_flag); end
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL mid_full got=%b exp=0", buffer_full); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", dut.state_reg, IDLE); end
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    #(12 * BIT_NS);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", valid_cnt - v0); end
    send_frame(8'h81, 1'b1, tf);
    #(BIT_NS);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL post_reset_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL post_reset_data got=%h exp=81", last_data); end
    checks++; if (cnt_at_valid !== 1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", cnt_at_valid); end
    $display("test_reset_mid_frame sent=81 got=%h", last_data);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_eos();
    test_back_to_back();
    test_frame_error();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
